// File: rtl/mux_pkg.sv
// Shared types and helpers for the arb_mux round-robin gatherer.
package mux_pkg;
  localparam int MAX_M    = 64;
  localparam int RST_DATA = 0;

  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_e;

  function automatic int num_src(input int s);
    return 1 << s;
  endfunction

  // First requesting index scanning ptr, ptr+1, ... modulo m; -1 when nothing requests.
  // The scan runs backwards so the smallest rotation offset is written last and wins.
  function automatic int rr_pick(input logic [MAX_M-1:0] req, input int ptr, input int m);
    int pick;
    int j;
    pick = -1;
    for (int k = MAX_M - 1; k >= 0; k--) begin
      j = (ptr + k) & (m - 1);
      if (k < m && req[j[5:0]]) pick = j;
    end
    return pick;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with optional packet lock; owns the rotation pointer and lock state.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int S = 1,
  localparam int M = num_src(S)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [M-1:0] req,
  input  logic         advance,
  input  logic         lock_hold,
  output logic [M-1:0] grant,
  output logic [S-1:0] grant_idx
);
  logic [S-1:0] ptr_q;
  logic         lock_q;
  logic [S-1:0] lock_idx_q;
  int           pick;

  always_comb begin
    pick      = rr_pick(MAX_M'(req), int'(ptr_q), M);
    grant     = '0;
    grant_idx = '0;
    if (lock_q) begin
      // While locked only the owner may be granted; an idle owner yields no grant at all.
      if (req[lock_idx_q]) begin
        grant_idx         = lock_idx_q;
        grant[lock_idx_q] = 1'b1;
      end
    end else if (pick >= 0) begin
      grant_idx        = S'(pick);
      grant[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (advance) begin
      if (lock_hold) begin
        lock_q     <= 1'b1;
        lock_idx_q <= grant_idx;
      end else begin
        lock_q <= 1'b0;
        ptr_q  <= grant_idx + 1'b1;
      end
    end
  end
endmodule

// File: rtl/arb_mux.sv
// Many-to-one valid/ready gatherer with round-robin arbitration and a registered output slot.
// Define ARB_MUX_LOCK_EN to add in_last and hold arbitration for a whole packet.
module arb_mux
  import mux_pkg::*;
#(
  parameter  int N = 2,
  parameter  int S = 1,
  localparam int M = num_src(S)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [M-1:0]        in_valid,
  input  logic [M-1:0][N-1:0] in_data,
  output logic [M-1:0]        in_ready,
`ifdef ARB_MUX_LOCK_EN
  input  logic [M-1:0]        in_last,
`endif
  output logic                out_valid,
  output logic [N-1:0]        out_data,
  output logic [S-1:0]        out_select,
  input  logic                out_ready
);
  slot_e        slot_q;
  logic [N-1:0] data_q;
  logic [S-1:0] sel_q;
  logic         load;
  logic         take;
  logic         lock_hold;
  logic [M-1:0] grant;
  logic [S-1:0] grant_idx;

  assign out_valid  = (slot_q == SLOT_FULL);
  assign out_data   = data_q;
  assign out_select = sel_q;

  // The slot can take a word when empty or when its current word leaves this cycle.
  assign load     = !out_valid || out_ready;
  assign in_ready = (load && !reset) ? grant : '0;
  assign take     = |in_ready;

`ifdef ARB_MUX_LOCK_EN
  assign lock_hold = ~|(in_last & grant);
`else
  assign lock_hold = 1'b0;
`endif

  rr_arbiter #(.S(S)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (in_valid),
    .advance   (take),
    .lock_hold (lock_hold),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= SLOT_EMPTY;
      data_q <= N'(RST_DATA);
      sel_q  <= '0;
    end else if (load) begin
      if (take) begin
        slot_q <= SLOT_FULL;
        data_q <= in_data[grant_idx];
        sel_q  <= grant_idx;
      end else begin
        slot_q <= SLOT_EMPTY;
      end
    end
  end
endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux (N=2, S=1); the lock sequence runs when ARB_MUX_LOCK_EN is defined.
module tb_arb_mux;
  localparam int N = 2;
  localparam int S = 1;
  localparam int M = 2;

  logic                clk;
  logic                reset;
  logic [M-1:0]        in_valid;
  logic [M-1:0][N-1:0] in_data;
  logic [M-1:0]        in_ready;
`ifdef ARB_MUX_LOCK_EN
  logic [M-1:0]        in_last;
`endif
  logic                out_valid;
  logic [N-1:0]        out_data;
  logic [S-1:0]        out_select;
  logic                out_ready;

  int checks = 0;
  int errors = 0;

  arb_mux #(.N(N), .S(S)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
`ifdef ARB_MUX_LOCK_EN
    .in_last    (in_last),
`endif
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_select (out_select),
    .out_ready  (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land on the following falling edge for sampling.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    $display("t=%0t in_valid=%b in_ready=%b out_valid=%b out_select=%0d out_data=%b",
             $time, in_valid, in_ready, out_valid, out_select, out_data);
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 2'b11;
    in_data[0] = 2'b01;
    in_data[1] = 2'b10;
    out_ready  = 1'b1;
`ifdef ARB_MUX_LOCK_EN
    in_last    = 2'b11;
`endif

    // Reset with both sources valid
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_select", 32'(out_select), 32'h0);
    reset    = 1'b0;
    in_valid = 2'b00;
    cyc();
    chk("post_rst_out_valid", 32'(out_valid), 32'h0);
    chk("post_rst_out_data", 32'(out_data), 32'h0);

    // Both sources continuously valid: grants alternate 0,1,0,1
    in_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_in_ready", 32'(in_ready), (i % 2 == 1) ? 32'h2 : 32'h1);
      cyc();
      chk("rr_out_valid", 32'(out_valid), 32'h1);
      chk("rr_out_select", 32'(out_select), 32'(i % 2));
      chk("rr_out_data", 32'(out_data), (i % 2 == 1) ? 32'h2 : 32'h1);
    end

    // Load 2'b11 from source 0, then stall the output for 5 cycles
    in_data[0] = 2'b11;
    in_valid   = 2'b01;
    #1;
    chk("load11_in_ready", 32'(in_ready), 32'h1);
    cyc();
    chk("load11_out_data", 32'(out_data), 32'h3);
    out_ready = 1'b0;
    in_valid  = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'h0);
      cyc();
      chk("stall_out_valid", 32'(out_valid), 32'h1);
      chk("stall_out_data", 32'(out_data), 32'h3);
      chk("stall_out_select", 32'(out_select), 32'h0);
    end
    // Drain and reload in the same cycle; pointer sits at 1
    out_ready = 1'b1;
    #1;
    chk("drain_in_ready", 32'(in_ready), 32'h2);
    cyc();
    chk("drain_out_valid", 32'(out_valid), 32'h1);
    chk("drain_out_select", 32'(out_select), 32'h1);
    chk("drain_out_data", 32'(out_data), 32'h2);

    // Only source 1 valid with pointer at 0; pointer then wraps back to 0
    in_valid = 2'b10;
    #1;
    chk("only1_in_ready", 32'(in_ready), 32'h2);
    cyc();
    chk("only1_out_select", 32'(out_select), 32'h1);
    chk("only1_out_data", 32'(out_data), 32'h2);
    in_valid = 2'b11;
    #1;
    chk("wrap_in_ready", 32'(in_ready), 32'h1);
    in_valid = 2'b01;
    #1;
    chk("only0_in_ready", 32'(in_ready), 32'h1);
    cyc();
    chk("only0_out_select", 32'(out_select), 32'h0);
    chk("only0_out_data", 32'(out_data), 32'h3);

    // Reset while the slot is full (pointer at 1): word discarded, source 0 first afterwards
    reset     = 1'b1;
    in_valid  = 2'b11;
    out_ready = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'h0);
    cyc();
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_out_data", 32'(out_data), 32'h0);
    chk("midrst_out_select", 32'(out_select), 32'h0);
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("after_rst_in_ready", 32'(in_ready), 32'h1);
    cyc();
    chk("after_rst_out_valid", 32'(out_valid), 32'h1);
    chk("after_rst_out_select", 32'(out_select), 32'h0);
    chk("after_rst_out_data", 32'(out_data), 32'h3);

    // No requests with out_ready high: slot empties
    in_valid = 2'b00;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'h0);
    cyc();
    chk("idle_out_valid", 32'(out_valid), 32'h0);

`ifdef ARB_MUX_LOCK_EN
    // Source 0 sends a 3-beat packet while source 1 waits
    reset = 1'b1;
    cyc();
    reset      = 1'b0;
    in_data[0] = 2'b01;
    in_valid   = 2'b11;
    for (int b = 0; b < 3; b++) begin
      in_last = (b == 2) ? 2'b11 : 2'b10;
      #1;
      chk("lock_in_ready", 32'(in_ready), 32'h1);
      cyc();
      chk("lock_out_select", 32'(out_select), 32'h0);
      chk("lock_out_data", 32'(out_data), 32'h1);
    end
    in_last = 2'b11;
    #1;
    chk("unlock_in_ready", 32'(in_ready), 32'h2);
    cyc();
    chk("unlock_out_select", 32'(out_select), 32'h1);
    chk("unlock_out_data", 32'(out_data), 32'h2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/arb_mux.md
Name: arb_mux

Overview:
- Many-to-one counterpart of the DEMUX utility.
- Gathers N-bit words from 2**S sources and forwards them over one valid/ready output channel.
- Arbitration is round-robin; the output is registered.
- Sits in Utilities and feeds shared resources (writeback bus, memory port) from several producers.

Parameters:
- N, 2, data word width in bits.
- S, 1, source index width; number of sources M = 2**S.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  M  per-source word-available flag.
- in_data  input  [M-1:0][N-1:0]  per-source data word.
- in_ready  output  M  per-source accept strobe; combinational.
- out_valid  output  1  output register holds a word.
- out_data  output  N  registered word.
- out_select  output  S  index of the source that supplied out_data.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. On the first clk edge with reset=1:
  - out_valid=0, out_data=0, out_select=0.
  - Round-robin pointer ptr=0; lock state cleared.
- While reset=1, in_ready=0.
- Output slot has two states, EMPTY (out_valid=0) and FULL (out_valid=1).
- load = !out_valid | out_ready. When load=0, all in_ready=0 and the output registers hold stable.
- Grant g: first index i with in_valid[i]=1, scanning ptr, ptr+1, …, ptr+M-1 modulo M. No grant if in_valid=0.
- When load=1 and a grant exists:
  - in_ready = one-hot(g).
  - Next edge: out_data <= in_data[g], out_select <= g, out_valid <= 1, ptr <= (g+1) mod M.
- When load=1 and no grant: in_ready=0; next edge out_valid <= 0 and ptr unchanged.
- Transfers:
  - Input transfer = in_valid[i] & in_ready[i].
  - Output transfer = out_valid & out_ready.
  - A simultaneous output drain and input load in the same cycle is legal, giving full throughput of one word per cycle.
- Latency: one cycle from input transfer to out_valid.
- in_ready never depends on in_data; it depends only on in_valid, ptr, out_valid and out_ready.
- Fairness: with all sources continuously valid, grants cycle 0,1,…,M-1,0. No source waits more than M-1 grants.
- Wrap-around: ptr increments modulo M; g=M-1 sets ptr=0.
- A source that drops in_valid before being granted is simply skipped; no state is kept for it.
- Reset mid-operation: a word held in the output register is discarded; no in_ready is asserted in the reset cycle.
- S=0 is not supported.

Optional Feature:
- Macro ARB_MUX_LOCK_EN.
- Defined:
  - Adds input in_last (M bits). The last beat of a source's packet is the transfer where in_last[i]=1.
  - After granting source g with in_last[g]=0, arbitration locks to g. Only g may be granted until a transfer from g with in_last[g]=1; other sources get in_ready=0 meanwhile.
  - ptr advances only on the last beat.
  - If locked source g deasserts in_valid, no grant occurs and the lock holds.
  - Reset clears the lock.
- Undefined: no in_last port; every transfer is treated as a last beat, giving the behaviour above.

Decomposition:
- Package mux_pkg:
  - Function clog-free M = 2**S helper.
  - Rotate-and-priority-encode function used for the grant.
  - Localparam for reset data value (0).
- One sub-module, rr_arbiter:
  - Ports: clk, reset, req (M), advance, lock_hold; outputs grant (one-hot M) and grant_idx (S).
  - Owns ptr and the lock state.
- arb_mux keeps the output register and the load logic.

Test Plan:
1. Reset with in_valid=2'b11 → in_ready=0 during reset; first cycle after reset, out_valid=0 and out_data=0.
2. N=2,S=1, out_ready=1, in_valid=2'b11, in_data[0]=2'b01, in_data[1]=2'b10 for 4 cycles → out_select sequence 0,1,0,1 and out_data 01,10,01,10, one cycle after each grant.
3. out_ready=0 with out_valid=1 holding data 2'b11 → in_ready=0 and out_data stays 2'b11 for 5 cycles. Raising out_ready → drain and new load in the same cycle.
4. Only in_valid=2'b10 with ptr=0 → grant index 1, ptr wraps to 0. Next in_valid=2'b01 → grant 0 the following cycle.
5. in_valid=2'b11 asserted in the same cycle as reset=1 while out_valid=1 → output word discarded; after reset, source 0 is granted first.
6. With ARB_MUX_LOCK_EN, source 0 sends 3 beats (in_last=0,0,1) while source 1 is valid → out_select 0,0,0 then 1; in_ready[1]=0 throughout the lock.
